// File: rtl/wra_inbuf_feeder.sv
// Input-buffer feeder: streams one row of input-RAM words per controller inputB_start into the Bt buffer.
// Optional zero-padding rows are enabled by defining WRA_FEEDER_ZPAD_EN (adds the zpad_op port).
module wra_inbuf_feeder #(
  parameter int DW     = 16,
  parameter int AW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_accord_inputbstart,
  input  logic          Channel_Switch_Done_6d,
  input  logic [8:0]    numslideH_op,
  input  logic [4:0]    numslideV_op,
  input  logic [AW-1:0] base_addr_op,
  input  logic [AW-1:0] row_stride_op,
`ifdef WRA_FEEDER_ZPAD_EN
  input  logic          zpad_op,
`endif
  output logic          in_rd_en,
  output logic [AW-1:0] in_rd_addr,
  input  logic [DW-1:0] in_rd_data,
  output logic [DW-1:0] bt_wr_data,
  output logic          bt_wr_valid,
  output logic          BtInB_Save_Done,
  output logic          Layer_Finish,
  output logic [4:0]    row_cnt
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] FETCH   = 3'd1;
  localparam logic [2:0] DRAIN   = 3'd2;
  localparam logic [2:0] DONE    = 3'd3;
  localparam logic [2:0] WAIT_SW = 3'd4;
  localparam logic [2:0] ARM     = 3'd5;
  localparam logic [2:0] LAST    = 3'd6;

  logic [2:0]        state;
  logic [8:0]        wcnt;
  logic [AW-1:0]     row_base;
  logic              iss;
  logic [RD_LAT-1:0] vpipe;
  logic [RD_LAT-1:0] ppipe;
  logic              pad_row;
  logic              pending;

  // Padding rows keep the word cadence but never touch the RAM.
  always_comb begin
    pad_row = 1'b0;
`ifdef WRA_FEEDER_ZPAD_EN
    if (zpad_op && ((row_cnt == 5'd0) || (row_cnt == numslideV_op))) begin
      pad_row = 1'b1;
    end else begin
      pad_row = 1'b0;
    end
`endif
  end

  // A row is still in flight while an issue slot or any non-final latency stage is occupied.
  always_comb begin
    pending = iss;
    for (int i = 0; i < RD_LAT - 1; i++) begin
      pending = pending | vpipe[i];
    end
  end

  assign bt_wr_valid = vpipe[RD_LAT-1];
  assign bt_wr_data  = (vpipe[RD_LAT-1] && !ppipe[RD_LAT-1]) ? in_rd_data : {DW{1'b0}};

  // Valid/pad flags follow each issue slot through the RAM read latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vpipe <= {RD_LAT{1'b0}};
      ppipe <= {RD_LAT{1'b0}};
    end else begin
      vpipe[0] <= iss;
      ppipe[0] <= iss & ~in_rd_en;
      for (int i = 1; i < RD_LAT; i++) begin
        vpipe[i] <= vpipe[i-1];
        ppipe[i] <= ppipe[i-1];
      end
    end
  end

  // Row sequencing FSM and registered RAM request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      wcnt            <= 9'd0;
      row_base        <= {AW{1'b0}};
      row_cnt         <= 5'd0;
      iss             <= 1'b0;
      in_rd_en        <= 1'b0;
      in_rd_addr      <= {AW{1'b0}};
      BtInB_Save_Done <= 1'b0;
      Layer_Finish    <= 1'b0;
    end else begin
      BtInB_Save_Done <= 1'b0;
      case (state)
        IDLE: begin
          if (en_accord_inputbstart) begin
            state    <= FETCH;
            wcnt     <= 9'd0;
            row_cnt  <= 5'd0;
            row_base <= base_addr_op;
          end
        end
        ARM: begin
          if (en_accord_inputbstart) begin
            state <= FETCH;
            wcnt  <= 9'd0;
          end
        end
        FETCH: begin
          iss        <= 1'b1;
          in_rd_en   <= ~pad_row;
          in_rd_addr <= row_base + AW'(wcnt);
          wcnt       <= wcnt + 9'd1;
          if (wcnt == numslideH_op) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          iss      <= 1'b0;
          in_rd_en <= 1'b0;
          if (!pending) begin
            BtInB_Save_Done <= 1'b1;
            Layer_Finish    <= (row_cnt == numslideV_op);
            state           <= DONE;
          end
        end
        DONE: begin
          state <= (row_cnt == numslideV_op) ? LAST : WAIT_SW;
        end
        WAIT_SW: begin
          if (Channel_Switch_Done_6d) begin
            row_cnt <= row_cnt + 5'd1;
            // After a padding row the next real row reuses the same RAM row.
            if (!pad_row) begin
              row_base <= row_base + row_stride_op;
            end
            state <= ARM;
          end
        end
        LAST: begin
          if (Channel_Switch_Done_6d) begin
            Layer_Finish <= 1'b0;
            row_cnt      <= 5'd0;
            state        <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wra_inbuf_feeder.sv
// Scoreboard bench: two feeders (RD_LAT 1 and 3) share one controller model; a monitor checks addresses, words, timing.
module tb_wra_inbuf_feeder;
  localparam int AW = 16;
  localparam int DW = 16;

  logic clk = 1'b0, rst = 1'b0, en = 1'b0, csd = 1'b0, zp = 1'b0;
  logic [8:0] h_op = 9'd0;
  logic [4:0] v_op = 5'd0;
  logic [AW-1:0] base_op = '0, stride_op = '0;

  logic          rd_en [2];
  logic [AW-1:0] rd_addr [2];
  logic [DW-1:0] rd_data [2];
  logic [DW-1:0] wr_data [2];
  logic          wr_valid [2];
  logic          sdone [2];
  logic          lfin [2];
  logic [4:0]    rcnt [2];

  int checks = 0, failures = 0, cyc = 0;
  int en_edge = 0, cur_h = 0;
  int done_cnt [2] = '{0, 0};
  logic [AW-1:0] exp_addr [2][$];
  logic [DW-1:0] exp_word [2][$];
  logic [5:0]    exp_done [2][$];
  logic [DW-1:0] ram1;
  logic [DW-1:0] ram3 [3];

  wra_inbuf_feeder #(.DW(DW), .AW(AW), .RD_LAT(1)) dut0 (
    .clk(clk), .rst(rst), .en_accord_inputbstart(en), .Channel_Switch_Done_6d(csd),
    .numslideH_op(h_op), .numslideV_op(v_op), .base_addr_op(base_op), .row_stride_op(stride_op),
`ifdef WRA_FEEDER_ZPAD_EN
    .zpad_op(zp),
`endif
    .in_rd_en(rd_en[0]), .in_rd_addr(rd_addr[0]), .in_rd_data(rd_data[0]),
    .bt_wr_data(wr_data[0]), .bt_wr_valid(wr_valid[0]), .BtInB_Save_Done(sdone[0]),
    .Layer_Finish(lfin[0]), .row_cnt(rcnt[0]));

  wra_inbuf_feeder #(.DW(DW), .AW(AW), .RD_LAT(3)) dut1 (
    .clk(clk), .rst(rst), .en_accord_inputbstart(en), .Channel_Switch_Done_6d(csd),
    .numslideH_op(h_op), .numslideV_op(v_op), .base_addr_op(base_op), .row_stride_op(stride_op),
`ifdef WRA_FEEDER_ZPAD_EN
    .zpad_op(zp),
`endif
    .in_rd_en(rd_en[1]), .in_rd_addr(rd_addr[1]), .in_rd_data(rd_data[1]),
    .bt_wr_data(wr_data[1]), .bt_wr_valid(wr_valid[1]), .BtInB_Save_Done(sdone[1]),
    .Layer_Finish(lfin[1]), .row_cnt(rcnt[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    logic [DW-1:0] t;
    t = a * 16'h9E37;
    return t + 16'h1234;
  endfunction

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Input RAM models: contents are a fixed function of the address.
  always @(posedge clk) begin
    ram1    <= mem(rd_addr[0]);
    ram3[0] <= mem(rd_addr[1]);
    ram3[1] <= ram3[0];
    ram3[2] <= ram3[1];
  end
  assign rd_data[0] = ram1;
  assign rd_data[1] = ram3[2];

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d: got %0h required %0h (cycle %0d)", name, d, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string name, input int d);
    checks++;
    failures++;
    $display("FAIL %s dut%0d: event seen with nothing expected (cycle %0d)", name, d, cyc);
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_rd_en"}, d, 32'(rd_en[d]), 32'd0);
      chk({tag, "_rd_addr"}, d, 32'(rd_addr[d]), 32'd0);
      chk({tag, "_wr_data"}, d, 32'(wr_data[d]), 32'd0);
      chk({tag, "_wr_valid"}, d, 32'(wr_valid[d]), 32'd0);
      chk({tag, "_save_done"}, d, 32'(sdone[d]), 32'd0);
      chk({tag, "_layer_finish"}, d, 32'(lfin[d]), 32'd0);
      chk({tag, "_row_cnt"}, d, 32'(rcnt[d]), 32'd0);
    end
  endtask

  // Expected words of one row, derived from the layer geometry.
  task automatic push_row(input int r, input int h, input int v, input logic [AW-1:0] base,
                          input logic [AW-1:0] stride, input logic zpad);
    logic pad;
    int er;
    logic [AW-1:0] a;
    pad = zpad && (r == 0 || r == v);
    er  = zpad ? r - 1 : r;
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w <= h; w++) begin
        a = base + AW'(er) * stride + AW'(w);
        if (!pad) exp_addr[d].push_back(a);
        exp_word[d].push_back(pad ? {DW{1'b0}} : mem(a));
      end
      exp_done[d].push_back({(r == v), 5'(r)});
    end
  endtask

  task automatic run_layer(input int h, input int v, input logic [AW-1:0] base,
                           input logic [AW-1:0] stride, input logic zpad_in, input int first_gap);
    int t0, t1;
    h_op = 9'(h); v_op = 5'(v); base_op = base; stride_op = stride;
`ifdef WRA_FEEDER_ZPAD_EN
    zp = zpad_in;
`else
    zp = 1'b0;
`endif
    for (int r = 0; r <= v; r++) begin
      repeat ((r == 0) ? first_gap : $urandom_range(0, 3)) @(posedge clk);
      @(posedge clk); #1;
      push_row(r, h, v, base, stride, zp);
      t0 = done_cnt[0] + 1;
      t1 = done_cnt[1] + 1;
      cur_h = h;
      en_edge = cyc + 1;
      en = 1'b1;
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
        en = 1'b0;
      end
      for (int k = 0; k < 300 && (done_cnt[0] < t0 || done_cnt[1] < t1); k++) begin
        @(posedge clk); #1;
      end
      if (done_cnt[0] < t0) note_fail("save_done_timeout", 0);
      if (done_cnt[1] < t1) note_fail("save_done_timeout", 1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1 en = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1 csd = 1'b1;
      @(posedge clk); #1;
      csd = 1'b0;
    end
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents a read, a word or a Save_Done.
  initial begin
    int vcount [2];
    int rdcount [2];
    logic lf_exp [2];
    logic [5:0] e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rst) begin
          vcount[d] = 0; rdcount[d] = 0; lf_exp[d] = 1'b0;
        end else begin
          if (rd_en[d]) begin
            if (rdcount[d] == 0) chk("first_read_cycle", d, 32'(cyc), 32'(en_edge + 1));
            rdcount[d]++;
            if (exp_addr[d].size() == 0) note_fail("unexpected_read", d);
            else chk("rd_addr", d, 32'(rd_addr[d]), 32'(exp_addr[d].pop_front()));
          end
          if (wr_valid[d]) begin
            if (vcount[d] == 0) chk("first_valid_cycle", d, 32'(cyc), 32'(en_edge + 1 + lat(d)));
            vcount[d]++;
            if (exp_word[d].size() == 0) note_fail("unexpected_word", d);
            else chk("bt_wr_data", d, 32'(wr_data[d]), 32'(exp_word[d].pop_front()));
          end
          if (sdone[d]) begin
            if (exp_done[d].size() == 0) note_fail("unexpected_save_done", d);
            else begin
              e = exp_done[d].pop_front();
              chk("save_done_cycle", d, 32'(cyc), 32'(en_edge + cur_h + lat(d) + 2));
              chk("words_per_row", d, 32'(vcount[d]), 32'(cur_h + 1));
              chk("row_cnt", d, 32'(rcnt[d]), 32'(e[4:0]));
              lf_exp[d] = e[5];
            end
            vcount[d] = 0;
            rdcount[d] = 0;
            done_cnt[d]++;
          end
          chk("layer_finish", d, 32'(lfin[d]), 32'(lf_exp[d]));
          if (csd) lf_exp[d] = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    rst = 1'b1;
    while (cyc < 8) begin @(posedge clk); #1; end
    // Single row with en seen at edge 10.
    run_layer(3, 0, 16'h0100, 16'h0000, 1'b0, 0);
    run_layer(1, 2, 16'h0000, 16'h0020, 1'b0, 2);
    run_layer(0, 0, 16'h0555, 16'h0010, 1'b0, 1);

    // Channel switch pulse while idle must be ignored.
    @(posedge clk); #1 csd = 1'b1;
    @(posedge clk); #1 csd = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("idle_csd_row_cnt", d, 32'(rcnt[d]), 32'd0);
      chk("idle_csd_layer_finish", d, 32'(lfin[d]), 32'd0);
    end

    // Reset mid-row after two reads.
    h_op = 9'd7; v_op = 5'd1; base_op = 16'h0300; stride_op = 16'h0040; zp = 1'b0;
    @(posedge clk); #1;
    push_row(0, 7, 1, 16'h0300, 16'h0040, 1'b0);
    cur_h = 7; en_edge = cyc + 1; en = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1 check_zero("midrow_reset");
    en = 1'b0;
    for (int d = 0; d < 2; d++) begin
      exp_addr[d].delete(); exp_word[d].delete(); exp_done[d].delete();
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);
    run_layer(7, 1, 16'h0300, 16'h0040, 1'b0, 1);

    for (int i = 0; i < 6; i++) begin
      run_layer($urandom_range(0, 6), $urandom_range(0, 3), 16'($urandom), 16'($urandom),
                1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end
`ifdef WRA_FEEDER_ZPAD_EN
    run_layer(2, 3, 16'h0800, 16'h0010, 1'b1, 1);
`endif
    repeat (10) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("leftover_addr", d, 32'(exp_addr[d].size()), 32'd0);
      chk("leftover_word", d, 32'(exp_word[d].size()), 32'd0);
      chk("leftover_done", d, 32'(exp_done[d].size()), 32'd0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
